// File: rtl/spi_master_fifo.sv
// spi_master_fifo: memory-mapped SPI master with TX/RX FIFOs, runtime CPOL/CPHA,
// bit order and clock divider. Frames stream back-to-back from the TX FIFO.
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   spi_select, mem_addr      register port chip select and word address
//   read_n, write_n           active-low read / write strobes (edge-qualified)
//   data_from_cpu             write data
//   data_to_cpu               registered read data
//   irq                       registered level interrupt
//   SCLK, MOSI, MISO          SPI bus
//   SS_n                      active-low slave selects
module spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RST    = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_select,
  input  logic [2:0]        mem_addr,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [15:0]       data_from_cpu,
  output logic [15:0]       data_to_cpu,
  output logic              irq,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state, next_state;

  // ---------------- access strobes ----------------
  logic rd_req, wr_req, rd_req_q, wr_req_q, rd_stb, wr_stb;
  assign rd_req = spi_select & ~read_n;
  assign wr_req = spi_select & ~write_n;
  assign rd_stb = rd_req & ~rd_req_q;
  assign wr_stb = wr_req & ~wr_req_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      rd_req_q <= rd_req;
      wr_req_q <= wr_req;
    end
  end

  // ---------------- configuration registers ----------------
  logic [5:0]        ien;
  logic              cpol, cpha, lsbfirst, sso;
  logic [15:0]       clkdiv;
  logic [NUM_SS-1:0] slave_en;
  logic              toe, roe;
  logic              busy;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ien      <= '0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      lsbfirst <= 1'b0;
      sso      <= 1'b0;
      clkdiv   <= 16'(DIV_RST);
      slave_en <= NUM_SS'(1);
    end else if (wr_stb) begin
      case (mem_addr)
        3'd3: begin
          ien <= data_from_cpu[5:0];
          sso <= data_from_cpu[11];
          if (!busy) begin
            cpol     <= data_from_cpu[8];
            cpha     <= data_from_cpu[9];
            lsbfirst <= data_from_cpu[10];
          end
        end
        3'd4: if (!busy) clkdiv <= data_from_cpu;
        3'd5: slave_en <= data_from_cpu[NUM_SS-1:0];
        default: ;
      endcase
    end
  end

  // ---------------- FIFOs ----------------
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]     tx_count, rx_count;
  logic              tx_wr, tx_push, tx_pop, rx_pop, rx_push;
  logic              load, push_req, toe_set, roe_set, stat_clr;
  logic [DATA_W-1:0] rx_word;

  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign tx_wr    = wr_stb && (mem_addr == 3'd1);
  assign tx_pop   = load;
  assign tx_push  = tx_wr && ((tx_count != FULL) || tx_pop);
  assign toe_set  = tx_wr && !tx_push;
  assign rx_pop   = rd_stb && (mem_addr == 3'd0) && (rx_count != '0);
  assign rx_push  = push_req && ((rx_count != FULL) || rx_pop);
  assign roe_set  = push_req && !rx_push;
  assign stat_clr = wr_stb && (mem_addr == 3'd2);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= data_from_cpu[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
      toe   <= 1'b0;
      roe   <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      if (toe_set)       toe <= 1'b1;
      else if (stat_clr) toe <= 1'b0;
      if (roe_set)       roe <= 1'b1;
      else if (stat_clr) roe <= 1'b0;
    end
  end

  // ---------------- half-period tick ----------------
  logic [15:0]   div_cnt;
  logic [EW-1:0] edge_cnt;
  logic          tick;

  assign tick = (state != IDLE) && (div_cnt == clkdiv);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    div_cnt <= '0;
    else if (state == IDLE || load)  div_cnt <= '0;
    else if (tick)                   div_cnt <= '0;
    else                             div_cnt <= div_cnt + 16'd1;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (tx_count != '0) next_state = SETUP;
      SETUP: if (tick) next_state = XFER;
      XFER:  if (tick && edge_cnt == LAST_EDGE) next_state = HOLD;
      HOLD:  if (tick) next_state = (tx_count != '0) ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  logic sclk_edge, shift_en, sample_en;
  always_comb begin
    load      = 1'b0;
    sclk_edge = 1'b0;
    shift_en  = 1'b0;
    sample_en = 1'b0;
    push_req  = 1'b0;
    case (state)
      IDLE: load = (tx_count != '0);
      XFER: begin
        sclk_edge = tick;
        // edge_cnt even => odd-numbered edge (1st, 3rd, ...)
        shift_en  = tick && (cpha ? !edge_cnt[0] : edge_cnt[0]);
        sample_en = tick && (cpha ? edge_cnt[0] : !edge_cnt[0]);
      end
      HOLD: begin
        push_req = tick;
        load     = tick && (tx_count != '0);
      end
      default: ;
    endcase
  end

  // ---------------- shift datapath ----------------
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  logic              miso_s1, miso_s2, sample_pend;
  logic [DATA_W-1:0] tx_sr, rx_sr;

  // The sample is applied one clk after the SCLK edge, so a registered MOSI looped
  // back through the two-flop synchroniser is still caught with CLKDIV>=1. A sample
  // still pending at the HOLD push is folded into the pushed word.
  assign rx_word = sample_pend ? shift_in(rx_sr, miso_s2, lsbfirst) : rx_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_s1     <= 1'b0;
      miso_s2     <= 1'b0;
      sample_pend <= 1'b0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      MOSI        <= 1'b0;
      SCLK        <= 1'b0;
      edge_cnt    <= '0;
    end else begin
      miso_s1     <= MISO;
      miso_s2     <= miso_s1;
      sample_pend <= sample_en;
      if (sample_pend) rx_sr <= rx_word;

      if (load) begin
        edge_cnt <= '0;
        if (cpha) begin
          tx_sr <= tx_mem[tx_rp];
        end else begin
          MOSI  <= first_bit(tx_mem[tx_rp], lsbfirst);
          tx_sr <= shift_out(tx_mem[tx_rp], lsbfirst);
        end
      end else if (shift_en) begin
        MOSI  <= first_bit(tx_sr, lsbfirst);
        tx_sr <= shift_out(tx_sr, lsbfirst);
      end

      if (sclk_edge) edge_cnt <= edge_cnt + EW'(1);

      if (state == IDLE)  SCLK <= cpol;
      else if (sclk_edge) SCLK <= ~SCLK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        SS_n <= '1;
    else if (load && state == IDLE)      SS_n <= ~slave_en;
    else if (next_state == IDLE)         SS_n <= sso ? ~slave_en : '1;
  end

  // ---------------- read port and interrupt ----------------
  logic       rrdy, trdy, tmt;
  logic [5:0] status;
  assign rrdy   = (rx_count != '0);
  assign trdy   = (tx_count != FULL);
  assign tmt    = (tx_count == '0) && (state == IDLE);
  assign status = {roe, toe, busy, tmt, trdy, rrdy};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      irq <= |(status & ien);
      if (rd_stb) begin
        case (mem_addr)
          3'd0: data_to_cpu <= rrdy ? 16'(rx_mem[rx_rp]) : '0;
          3'd2: data_to_cpu <= {10'd0, status};
          3'd3: data_to_cpu <= {4'd0, sso, lsbfirst, cpha, cpol, 2'd0, ien};
          3'd4: data_to_cpu <= clkdiv;
          3'd5: data_to_cpu <= 16'(slave_en);
          3'd6: data_to_cpu <= {8'(rx_count), 8'(tx_count)};
          default: data_to_cpu <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
module tb_spi_master_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        spi_select = 1'b0;
  logic [2:0]  mem_addr = 3'd0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_from_cpu = 16'd0;
  logic [15:0] data_to_cpu;
  logic        irq, SCLK, MOSI, MISO;
  logic [1:0]  SS_n;

  // loopback: MISO follows MOSI
  assign MISO = MOSI;

  spi_master_fifo #(.DATA_W(8), .NUM_SS(2), .FIFO_DEPTH(4), .DIV_RST(24)) dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
    @(posedge clk); #1;
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
    @(posedge clk); #1;
    d = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    logic [15:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      cpu_read(3'd2, s);
      if (s[2] && !s[3]) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got still busy expected idle within budget", name);
    end
  endtask

  // ---------------- behavioural SPI slave (SS_n[0]) ----------------
  bit          cpha_m = 1'b0;
  bit          lsb_m  = 1'b0;
  int          sl_edges = 0;
  int          sl_bits  = 0;
  logic [7:0]  sl_word  = 8'd0;
  logic        sl_prev  = 1'b0;
  logic [7:0]  slave_q [$];
  int          ss_fall = 0;

  always @(SCLK or SS_n[0]) begin
    if (SS_n[0] !== 1'b0) begin
      sl_edges = 0;
      sl_bits  = 0;
    end else if (SCLK !== sl_prev) begin
      sl_edges++;
      // CPHA=0 samples on odd (leading) edges, CPHA=1 on even (trailing) edges
      if (((sl_edges % 2) == 1) != cpha_m) begin
        if (lsb_m) sl_word[3'(sl_bits)] = MOSI;
        else       sl_word[3'(7 - sl_bits)] = MOSI;
        sl_bits++;
      end
      if (sl_edges == 16) begin
        slave_q.push_back(sl_word);
        sl_edges = 0;
        sl_bits  = 0;
      end
    end
    sl_prev = SCLK;
  end

  always @(negedge SS_n[0]) ss_fall++;

  // ---------------- register table ----------------
  typedef struct {
    logic [2:0]  addr;
    bit          is_wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  logic [15:0] rd;
  logic [7:0]  mbits, w;
  logic        prev_sclk, cpol_r, cpha_r, lsb_r;
  int          ss_low, rises, high_cnt, nb, k;
  bit          seen_low, seen_rise;
  logic [7:0]  model_q [$];
  logic [7:0]  sent_q  [$];

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'd3, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{3'd4, 1'b0, 16'h0000, 16'd24};
    vecs[2]  = '{3'd5, 1'b0, 16'h0000, 16'h0001};
    vecs[3]  = '{3'd2, 1'b0, 16'h0000, 16'h0006};
    vecs[4]  = '{3'd6, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{3'd0, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{3'd7, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{3'd3, 1'b1, 16'hFFFF, 16'h0000};
    vecs[8]  = '{3'd3, 1'b0, 16'h0000, 16'h0F3F};
    vecs[9]  = '{3'd5, 1'b1, 16'hFFFF, 16'h0000};
    vecs[10] = '{3'd5, 1'b0, 16'h0000, 16'h0003};
    vecs[11] = '{3'd4, 1'b1, 16'h1234, 16'h0000};
    vecs[12] = '{3'd4, 1'b0, 16'h0000, 16'h1234};
    vecs[13] = '{3'd7, 1'b1, 16'hFFFF, 16'h0000};
    vecs[14] = '{3'd7, 1'b0, 16'h0000, 16'h0000};
    vecs[15] = '{3'd3, 1'b1, 16'h0000, 16'h0000};
    vecs[16] = '{3'd3, 1'b0, 16'h0000, 16'h0000};
    vecs[17] = '{3'd5, 1'b1, 16'h0001, 16'h0000};
    vecs[18] = '{3'd5, 1'b0, 16'h0000, 16'h0001};

    // reset
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", 16'(SS_n), 16'h0003);
    check("rst_sclk", 16'(SCLK), 16'h0000);
    check("rst_mosi", 16'(MOSI), 16'h0000);
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_data", data_to_cpu, 16'h0000);
    @(posedge clk); #1 reset_n = 1'b1;

    // register table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) cpu_write(vecs[i].addr, vecs[i].wdata);
      else begin
        cpu_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // mode 0, CLKDIV=1, loopback of 0xA5
    cpu_write(3'd4, 16'd1);
    cpu_write(3'd3, 16'h0000);
    cpu_write(3'd1, 16'h00A5);
    ss_low = 0; rises = 0; high_cnt = 0; nb = 0; mbits = '0; prev_sclk = SCLK;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (!SS_n[0]) ss_low++;
      if (SCLK && !prev_sclk) begin
        if (nb < 8) mbits[3'(7 - nb)] = MOSI;
        nb++;
        rises++;
      end
      if (SCLK) high_cnt++;
      prev_sclk = SCLK;
    end
    check("t1_ss_low_cycles", 16'(ss_low), 16'd36);
    check("t1_sclk_pulses", 16'(rises), 16'd8);
    check("t1_sclk_high_cycles", 16'(high_cnt), 16'd16);
    check("t1_mosi_bits", 16'(mbits), 16'h00A5);
    check("t1_ss_idle", 16'(SS_n), 16'h0003);
    cpu_read(3'd0, rd);
    check("t1_rxdata", rd, 16'h00A5);

    // all four modes, LSB first, 0x01 into the slave model
    for (int m = 0; m < 4; m++) begin
      cpol_r = m[1];
      cpha_r = m[0];
      cpha_m = cpha_r;
      lsb_m  = 1'b1;
      cpu_write(3'd3, {5'd0, 1'b1, cpha_r, cpol_r, 8'd0});
      repeat (2) @(posedge clk);
      #1 check($sformatf("mode%0d_sclk_idle_pre", m), 16'(SCLK), 16'(cpol_r));
      slave_q.delete();
      ss_fall = 0;
      cpu_write(3'd1, 16'h0001);
      wait_idle($sformatf("mode%0d_idle", m));
      check($sformatf("mode%0d_slave_count", m), 16'(slave_q.size()), 16'd1);
      if (slave_q.size() > 0) check($sformatf("mode%0d_slave_word", m), 16'(slave_q[0]), 16'h0001);
      check($sformatf("mode%0d_ss_falls", m), 16'(ss_fall), 16'd1);
      check($sformatf("mode%0d_sclk_idle_post", m), 16'(SCLK), 16'(cpol_r));
      cpu_read(3'd0, rd);
      check($sformatf("mode%0d_rxdata", m), rd, 16'h0001);
    end

    // TX overflow then RX overflow, depth 4
    cpu_write(3'd3, 16'h0000);
    cpu_write(3'd4, 16'd7);
    cpha_m = 1'b0; lsb_m = 1'b0;
    slave_q.delete();
    ss_fall = 0;
    for (int i = 1; i <= 6; i++) cpu_write(3'd1, 16'(i * 16'h11));
    cpu_read(3'd2, rd);
    check("ovf_status_busy", rd, 16'h0018);
    cpu_read(3'd6, rd);
    check("ovf_levels_busy", rd, 16'h0004);
    wait_idle("ovf_idle");
    check("ovf_ss_falls", 16'(ss_fall), 16'd1);
    check("ovf_slave_count", 16'(slave_q.size()), 16'd5);
    cpu_read(3'd2, rd);
    check("ovf_status_idle", rd, 16'h0037);
    cpu_read(3'd6, rd);
    check("ovf_levels_idle", rd, 16'h0400);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd);
    check("ovf_status_clr", rd, 16'h0007);
    for (int i = 1; i <= 4; i++) begin
      cpu_read(3'd0, rd);
      check($sformatf("ovf_rx%0d", i), rd, 16'(i * 16'h11));
    end
    cpu_read(3'd2, rd);
    check("ovf_status_drained", rd, 16'h0006);

    // RRDY interrupt timing
    cpu_write(3'd4, 16'd1);
    cpu_write(3'd3, 16'h0001);
    cpu_write(3'd1, 16'h005A);
    seen_low = 1'b0; seen_rise = 1'b0;
    for (int c = 0; c < 200 && !seen_rise; c++) begin
      @(posedge clk); #1;
      if (!SS_n[0]) seen_low = 1'b1;
      else if (seen_low) begin
        seen_rise = 1'b1;
        check("irq_at_push", 16'(irq), 16'h0000);
        @(posedge clk); #1;
        check("irq_after_push", 16'(irq), 16'h0001);
      end
    end
    total++;
    if (!seen_rise) begin
      bad++;
      $display("FAIL irq_frame_end: got no SS_n release expected release within budget");
    end
    cpu_read(3'd0, rd);
    check("irq_rxdata", rd, 16'h005A);
    check("irq_held_at_pop", 16'(irq), 16'h0001);
    @(posedge clk); #1;
    check("irq_dropped", 16'(irq), 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // randomized bursts against a queue model
    for (int it = 0; it < 12; it++) begin
      cpol_r = 1'($urandom);
      cpha_r = 1'($urandom);
      lsb_r  = 1'($urandom);
      cpha_m = cpha_r;
      lsb_m  = lsb_r;
      cpu_write(3'd4, 16'($urandom_range(1, 3)));
      cpu_write(3'd3, {5'd0, lsb_r, cpha_r, cpol_r, 8'd0});
      slave_q.delete();
      sent_q.delete();
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        w = 8'($urandom_range(0, 255));
        model_q.push_back(w);
        sent_q.push_back(w);
        cpu_write(3'd1, 16'(w));
      end
      wait_idle($sformatf("rnd%0d_idle", it));
      cpu_read(3'd6, rd);
      check($sformatf("rnd%0d_levels", it), rd, 16'(k << 8));
      for (int j = 0; j < k; j++) begin
        cpu_read(3'd0, rd);
        check($sformatf("rnd%0d_rx%0d", it, j), rd, 16'(model_q.pop_front()));
      end
      check($sformatf("rnd%0d_slave_count", it), 16'(slave_q.size()), 16'(k));
      for (int j = 0; j < k && j < slave_q.size(); j++)
        check($sformatf("rnd%0d_slave%0d", it, j), 16'(slave_q[j]), 16'(sent_q[j]));
    end

    // reset mid-XFER
    cpu_write(3'd4, 16'd3);
    cpu_write(3'd3, 16'h0000);
    cpu_write(3'd1, 16'h003C);
    cpu_write(3'd1, 16'h00C3);
    repeat (30) @(posedge clk);
    #1 check("mid_ss_active", 16'(SS_n[0]), 16'h0000);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_ss_n", 16'(SS_n), 16'h0003);
    check("mid_rst_sclk", 16'(SCLK), 16'h0000);
    check("mid_rst_mosi", 16'(MOSI), 16'h0000);
    @(posedge clk); #1 reset_n = 1'b1;
    cpu_read(3'd6, rd);
    check("mid_rst_levels", rd, 16'h0000);
    cpu_read(3'd4, rd);
    check("mid_rst_clkdiv", rd, 16'd24);
    cpu_read(3'd2, rd);
    check("mid_rst_status", rd, 16'h0006);
    repeat (20) @(posedge clk);
    #1 check("mid_rst_ss_stays", 16'(SS_n), 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
